// File: rtl/asrv32_decoder_stage_pkg.sv
// Shared decode encodings for the ASRV32 decode stage: raw opcode/funct
// constants, one-hot bit positions of the decoded bundle, and the bundle type.
package asrv32_decoder_stage_pkg;

    // Raw 7-bit major opcodes
    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;

    // funct3 values (ALU / shift)
    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    // funct3 values (branches)
    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    // funct7 values
    localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    // One-hot opcode class positions
    localparam int unsigned OPCODE_WIDTH = 11;
    localparam int unsigned OPC_RTYPE    = 0;
    localparam int unsigned OPC_ITYPE    = 1;
    localparam int unsigned OPC_LOAD     = 2;
    localparam int unsigned OPC_STORE    = 3;
    localparam int unsigned OPC_BRANCH   = 4;
    localparam int unsigned OPC_JAL      = 5;
    localparam int unsigned OPC_JALR     = 6;
    localparam int unsigned OPC_LUI      = 7;
    localparam int unsigned OPC_AUIPC    = 8;
    localparam int unsigned OPC_SYSTEM   = 9;
    localparam int unsigned OPC_FENCE    = 10;

    // One-hot ALU operation positions
    localparam int unsigned ALU_WIDTH = 14;
    localparam int unsigned ALU_ADD   = 0;
    localparam int unsigned ALU_SUB   = 1;
    localparam int unsigned ALU_SLT   = 2;
    localparam int unsigned ALU_SLTU  = 3;
    localparam int unsigned ALU_XOR   = 4;
    localparam int unsigned ALU_OR    = 5;
    localparam int unsigned ALU_AND   = 6;
    localparam int unsigned ALU_SLL   = 7;
    localparam int unsigned ALU_SRL   = 8;
    localparam int unsigned ALU_SRA   = 9;
    localparam int unsigned ALU_EQ    = 10;
    localparam int unsigned ALU_NEQ   = 11;
    localparam int unsigned ALU_GE    = 12;
    localparam int unsigned ALU_GEU   = 13;

    // One-hot MUL/DIV positions (index equals funct3)
    localparam int unsigned MDU_WIDTH  = 8;
    localparam int unsigned MDU_MUL    = 0;
    localparam int unsigned MDU_MULH   = 1;
    localparam int unsigned MDU_MULHSU = 2;
    localparam int unsigned MDU_MULHU  = 3;
    localparam int unsigned MDU_DIV    = 4;
    localparam int unsigned MDU_DIVU   = 5;
    localparam int unsigned MDU_REM    = 6;
    localparam int unsigned MDU_REMU   = 7;

    // SYSTEM sub-op positions
    localparam int unsigned SYS_WIDTH  = 3;
    localparam int unsigned SYS_ECALL  = 0;
    localparam int unsigned SYS_EBREAK = 1;
    localparam int unsigned SYS_MRET   = 2;

    // Decoded bundle (register-width independent part)
    typedef struct packed {
        logic [31:0]             imm;
        logic [2:0]              funct3;
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [ALU_WIDTH-1:0]    alu;
        logic [MDU_WIDTH-1:0]    mdu;
        logic [SYS_WIDTH-1:0]    sys;
        logic                    illegal;
    } dec_t;

    // Register/immediate ALU op from funct3; alt selects SUB/SRA
    function automatic logic [ALU_WIDTH-1:0] alu_from_funct3(input logic [2:0] funct3,
                                                            input logic       alt);
        logic [ALU_WIDTH-1:0] a;
        a = '0;
        case (funct3)
            FUNCT3_ADD:  a[alt ? ALU_SUB : ALU_ADD] = 1'b1;
            FUNCT3_SLL:  a[ALU_SLL]                 = 1'b1;
            FUNCT3_SLT:  a[ALU_SLT]                 = 1'b1;
            FUNCT3_SLTU: a[ALU_SLTU]                = 1'b1;
            FUNCT3_XOR:  a[ALU_XOR]                 = 1'b1;
            FUNCT3_SR:   a[alt ? ALU_SRA : ALU_SRL] = 1'b1;
            FUNCT3_OR:   a[ALU_OR]                  = 1'b1;
            default:     a[ALU_AND]                 = 1'b1;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/asrv32_decoder_stage_decode_comb.sv
// Pure combinational RV32I/E(+M) decoder producing the decoded bundle.
module asrv32_decode_comb
    import asrv32_decoder_stage_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          EN_MEXT    = 1'b1
) (
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0]              funct7;
    logic [2:0]              funct3;
    logic                    illegal;
    logic                    use_rs1;
    logic                    use_rs2;
    logic                    use_rd;
    logic [OPCODE_WIDTH-1:0] opc;
    logic [ALU_WIDTH-1:0]    alu;
    logic [MDU_WIDTH-1:0]    mdu;
    logic [SYS_WIDTH-1:0]    sys;
    logic [31:0]             imm;
    logic [31:0]             imm_i;
    logic [31:0]             imm_s;
    logic [31:0]             imm_b;
    logic [31:0]             imm_j;
    logic [31:0]             imm_u;
    logic [31:0]             imm_z;

    assign funct7 = inst[31:25];
    assign funct3 = inst[14:12];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_z  = {20'b0, inst[31:20]};

    // Opcode class, ALU/MDU/SYS op, immediate and illegal detection
    always_comb begin
        illegal = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        opc     = '0;
        alu     = '0;
        mdu     = '0;
        sys     = '0;
        imm     = '0;

        if (inst[1:0] != 2'b11) illegal = 1'b1;

        case (inst[6:0])
            OPCODE_RTYPE: begin
                opc[OPC_RTYPE] = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                if (funct7 == FUNCT7_ZERO)
                    alu = alu_from_funct3(funct3, 1'b0);
                else if (funct7 == FUNCT7_ALT && (funct3 == FUNCT3_ADD || funct3 == FUNCT3_SR))
                    alu = alu_from_funct3(funct3, 1'b1);
                else if (funct7 == FUNCT7_MEXT && EN_MEXT)
                    mdu[funct3] = 1'b1;
                else
                    illegal = 1'b1;
            end
            OPCODE_ITYPE: begin
                opc[OPC_ITYPE] = 1'b1;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm     = imm_i;
                if (funct3 == FUNCT3_SLL) begin
                    alu[ALU_SLL] = 1'b1;
                    if (funct7 != FUNCT7_ZERO) illegal = 1'b1;
                end else if (funct3 == FUNCT3_SR) begin
                    if (funct7 == FUNCT7_ZERO)     alu[ALU_SRL] = 1'b1;
                    else if (funct7 == FUNCT7_ALT) alu[ALU_SRA] = 1'b1;
                    else                           illegal      = 1'b1;
                end else begin
                    alu = alu_from_funct3(funct3, 1'b0);
                end
            end
            OPCODE_LOAD: begin
                opc[OPC_LOAD] = 1'b1;
                alu[ALU_ADD]  = 1'b1;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm     = imm_i;
            end
            OPCODE_STORE: begin
                opc[OPC_STORE] = 1'b1;
                alu[ALU_ADD]   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = imm_s;
            end
            OPCODE_BRANCH: begin
                opc[OPC_BRANCH] = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = imm_b;
                case (funct3)
                    FUNCT3_BEQ:  alu[ALU_EQ]   = 1'b1;
                    FUNCT3_BNE:  alu[ALU_NEQ]  = 1'b1;
                    FUNCT3_BLT:  alu[ALU_SLT]  = 1'b1;
                    FUNCT3_BGE:  alu[ALU_GE]   = 1'b1;
                    FUNCT3_BLTU: alu[ALU_SLTU] = 1'b1;
                    FUNCT3_BGEU: alu[ALU_GEU]  = 1'b1;
                    default:     illegal       = 1'b1;
                endcase
            end
            OPCODE_JAL: begin
                opc[OPC_JAL] = 1'b1;
                alu[ALU_ADD] = 1'b1;
                use_rd = 1'b1;
                imm    = imm_j;
            end
            OPCODE_JALR: begin
                opc[OPC_JALR] = 1'b1;
                alu[ALU_ADD]  = 1'b1;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm     = imm_i;
                if (funct3 != 3'b000) illegal = 1'b1;
            end
            OPCODE_LUI: begin
                opc[OPC_LUI] = 1'b1;
                alu[ALU_ADD] = 1'b1;
                use_rd = 1'b1;
                imm    = imm_u;
            end
            OPCODE_AUIPC: begin
                opc[OPC_AUIPC] = 1'b1;
                alu[ALU_ADD]   = 1'b1;
                use_rd = 1'b1;
                imm    = imm_u;
            end
            OPCODE_SYSTEM: begin
                opc[OPC_SYSTEM] = 1'b1;
                alu[ALU_ADD]    = 1'b1;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm     = imm_z;
                if (funct3 == 3'b000 && inst[19:15] == 5'd0 && inst[11:7] == 5'd0) begin
                    case (inst[31:20])
                        12'h000: sys[SYS_ECALL]  = 1'b1;
                        12'h001: sys[SYS_EBREAK] = 1'b1;
                        12'h302: sys[SYS_MRET]   = 1'b1;
                        default: sys = '0;
                    endcase
                end
            end
            OPCODE_FENCE: begin
                opc[OPC_FENCE] = 1'b1;
                alu[ALU_ADD]   = 1'b1;
                imm            = imm_z;
            end
            default: illegal = 1'b1;
        endcase

        // RV32E: only x0..x15 exist
        if (REG_ADDR_W == 4 &&
            ((use_rs1 && inst[19]) || (use_rs2 && inst[24]) || (use_rd && inst[11])))
            illegal = 1'b1;

        if (illegal) begin
            opc = '0;
            alu = '0;
            mdu = '0;
            sys = '0;
        end
    end

    // Pack the bundle
    always_comb begin
        dec         = '0;
        dec.imm     = imm;
        dec.funct3  = funct3;
        dec.opcode  = opc;
        dec.alu     = alu;
        dec.mdu     = mdu;
        dec.sys     = sys;
        dec.illegal = illegal;
    end

endmodule

// File: rtl/asrv32_decoder_stage.sv
// ASRV32 decode pipeline stage: valid/ready output register, optional skid
// entry and flush around the combinational decoder.
module asrv32_decoder_stage
    import asrv32_decoder_stage_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          EN_MEXT    = 1'b1,
    parameter bit          EN_SKID    = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [31:0]             i_inst,
    input  logic [31:0]             i_pc,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_flush,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [REG_ADDR_W-1:0]   o_rs1_addr,
    output logic [REG_ADDR_W-1:0]   o_rs2_addr,
    output logic [REG_ADDR_W-1:0]   o_rd_addr,
    output logic [31:0]             o_pc,
    output logic [31:0]             o_imm,
    output logic [2:0]              o_funct3,
    output logic [OPCODE_WIDTH-1:0] o_opcode,
    output logic [ALU_WIDTH-1:0]    o_alu_op,
    output logic [MDU_WIDTH-1:0]    o_mdu_op,
    output logic [SYS_WIDTH-1:0]    o_sys_op,
    output logic                    o_illegal
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [31:0]           pc;
        dec_t                  dec;
    } entry_t;

    dec_t   in_dec;
    entry_t in_entry;
    entry_t out_q;
    entry_t skid_q;
    logic   out_valid;
    logic   skid_valid;
    logic   ready_q;
    logic   accept;

    asrv32_decode_comb #(
        .REG_ADDR_W (REG_ADDR_W),
        .EN_MEXT    (EN_MEXT)
    ) u_decode (
        .inst (i_inst),
        .dec  (in_dec)
    );

    // Assemble the incoming entry from the decoded bundle
    always_comb begin
        in_entry     = '0;
        in_entry.rd  = i_inst[7 +: REG_ADDR_W];
        in_entry.pc  = i_pc;
        in_entry.dec = in_dec;
    end

    assign o_ready = EN_SKID ? ready_q : (!out_valid || i_ready);
    assign accept  = i_valid && o_ready;

    // Output register, skid entry and flush handling
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (EN_SKID) begin
            // ready_q tracks !skid_valid one cycle ahead so o_ready is a flop
            if (i_flush) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
                ready_q    <= 1'b1;
            end else if (!out_valid || i_ready) begin
                if (skid_valid) begin
                    out_q      <= skid_q;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= accept;
                    if (accept) out_q <= in_entry;
                end
                ready_q <= 1'b1;
            end else if (accept) begin
                skid_q     <= in_entry;
                skid_valid <= 1'b1;
                ready_q    <= 1'b0;
            end
        end else begin
            if (i_flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_q     <= in_entry;
                out_valid <= 1'b1;
            end else if (i_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign o_valid    = out_valid;
    assign o_rs1_addr = i_inst[15 +: REG_ADDR_W];
    assign o_rs2_addr = i_inst[20 +: REG_ADDR_W];
    assign o_rd_addr  = out_q.rd;
    assign o_pc       = out_q.pc;
    assign o_imm      = out_q.dec.imm;
    assign o_funct3   = out_q.dec.funct3;
    assign o_opcode   = out_q.dec.opcode;
    assign o_alu_op   = out_q.dec.alu;
    assign o_mdu_op   = out_q.dec.mdu;
    assign o_sys_op   = out_q.dec.sys;
    assign o_illegal  = out_q.dec.illegal;

endmodule

// File: tb/tb_asrv32_decoder_stage.sv
// Directed bench: instance A is RV32I+M with skid, instance B is RV32E, no M, no skid.
module tb_asrv32_decoder_stage;

    // Expected one-hot encodings
    localparam logic [10:0] E_RTYPE  = 11'h001;
    localparam logic [10:0] E_ITYPE  = 11'h002;
    localparam logic [10:0] E_LOAD   = 11'h004;
    localparam logic [10:0] E_STORE  = 11'h008;
    localparam logic [10:0] E_BRANCH = 11'h010;
    localparam logic [10:0] E_JAL    = 11'h020;
    localparam logic [10:0] E_LUI    = 11'h080;
    localparam logic [10:0] E_SYSTEM = 11'h200;
    localparam logic [13:0] E_ADD    = 14'h0001;
    localparam logic [13:0] E_SUB    = 14'h0002;
    localparam logic [13:0] E_SRA    = 14'h0200;
    localparam logic [13:0] E_NEQ    = 14'h0800;

    logic        clk = 1'b0;
    logic        rst, valid, flush, ready;
    logic [31:0] inst, pc;

    logic        a_ready, a_valid, a_ill;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [31:0] a_pc, a_imm;
    logic [2:0]  a_f3, a_sys;
    logic [10:0] a_opc;
    logic [13:0] a_alu;
    logic [7:0]  a_mdu;

    logic        b_ready, b_valid, b_ill;
    logic [3:0]  b_rs1, b_rs2, b_rd;
    logic [31:0] b_pc, b_imm;
    logic [2:0]  b_f3, b_sys;
    logic [10:0] b_opc;
    logic [13:0] b_alu;
    logic [7:0]  b_mdu;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    asrv32_decoder_stage #(.REG_ADDR_W(5), .EN_MEXT(1'b1), .EN_SKID(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_inst(inst), .i_pc(pc), .i_valid(valid),
        .o_ready(a_ready), .i_flush(flush), .o_valid(a_valid), .i_ready(ready),
        .o_rs1_addr(a_rs1), .o_rs2_addr(a_rs2), .o_rd_addr(a_rd), .o_pc(a_pc),
        .o_imm(a_imm), .o_funct3(a_f3), .o_opcode(a_opc), .o_alu_op(a_alu),
        .o_mdu_op(a_mdu), .o_sys_op(a_sys), .o_illegal(a_ill)
    );

    asrv32_decoder_stage #(.REG_ADDR_W(4), .EN_MEXT(1'b0), .EN_SKID(1'b0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_inst(inst), .i_pc(pc), .i_valid(valid),
        .o_ready(b_ready), .i_flush(flush), .o_valid(b_valid), .i_ready(ready),
        .o_rs1_addr(b_rs1), .o_rs2_addr(b_rs2), .o_rd_addr(b_rd), .o_pc(b_pc),
        .o_imm(b_imm), .o_funct3(b_f3), .o_opcode(b_opc), .o_alu_op(b_alu),
        .o_mdu_op(b_mdu), .o_sys_op(b_sys), .o_illegal(b_ill)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; flush = 1'b0; ready = 1'b1;
        inst = 32'h0; pc = 32'h0;
        tick(); tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got %0h exp 0", a_valid); end
        checks++; if (a_imm !== 32'h0) begin errors++; $display("FAIL rst_a_imm got %h exp 0", a_imm); end
        checks++; if (a_alu !== 14'h0) begin errors++; $display("FAIL rst_a_alu got %h exp 0", a_alu); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready_in_reset got %0h exp 0", a_ready); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got %0h exp 0", b_valid); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready got %0h exp 1", b_ready); end
        rst = 1'b0;
        tick();
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready_after got %0h exp 1", a_ready); end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid_after got %0h exp 0", a_valid); end
    endtask

    task automatic test_sub();
        inst = 32'h402081B3; pc = 32'h0000_0100; valid = 1'b1; ready = 1'b1;
        #1;
        checks++; if (a_rs1 !== 5'd1) begin errors++; $display("FAIL sub_rs1 got %0d exp 1", a_rs1); end
        checks++; if (a_rs2 !== 5'd2) begin errors++; $display("FAIL sub_rs2 got %0d exp 2", a_rs2); end
        tick();
        valid = 1'b0;
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL sub_valid got %0h exp 1", a_valid); end
        checks++; if (a_alu !== E_SUB) begin errors++; $display("FAIL sub_alu got %h exp %h", a_alu, E_SUB); end
        checks++; if (a_rd !== 5'd3) begin errors++; $display("FAIL sub_rd got %0d exp 3", a_rd); end
        checks++; if (a_ill !== 1'b0) begin errors++; $display("FAIL sub_illegal got %0h exp 0", a_ill); end
        checks++; if (a_opc !== E_RTYPE) begin errors++; $display("FAIL sub_opcode got %h exp %h", a_opc, E_RTYPE); end
        checks++; if (a_pc !== 32'h100) begin errors++; $display("FAIL sub_pc got %h exp 100", a_pc); end
        checks++; if (b_alu !== E_SUB || b_rd !== 4'd3 || b_ill !== 1'b0)
            begin errors++; $display("FAIL sub_b got alu=%h rd=%0d ill=%0h exp alu=%h rd=3 ill=0", b_alu, b_rd, b_ill, E_SUB); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL sub_drain got %0h exp 0", a_valid); end
    endtask

    task automatic test_back_to_back();
        inst = 32'h123452B7; pc = 32'h200; valid = 1'b1; ready = 1'b1;
        tick();
        checks++; if (a_imm !== 32'h12345000) begin errors++; $display("FAIL b2b_lui_imm got %h exp 12345000", a_imm); end
        checks++; if (a_opc !== E_LUI || a_rd !== 5'd5) begin errors++; $display("FAIL b2b_lui_op got opc=%h rd=%0d exp %h rd=5", a_opc, a_rd, E_LUI); end
        inst = 32'h022081B3; pc = 32'h204;
        tick();
        valid = 1'b0;
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble got %0h exp 1", a_valid); end
        checks++; if (a_mdu !== 8'h01) begin errors++; $display("FAIL b2b_mul_mdu got %h exp 01", a_mdu); end
        checks++; if (a_alu !== 14'h0 || a_ill !== 1'b0) begin errors++; $display("FAIL b2b_mul_alu got alu=%h ill=%0h exp 0/0", a_alu, a_ill); end
        checks++; if (a_pc !== 32'h204) begin errors++; $display("FAIL b2b_mul_pc got %h exp 204", a_pc); end
        checks++; if (b_ill !== 1'b1 || b_mdu !== 8'h0 || b_opc !== 11'h0)
            begin errors++; $display("FAIL b2b_nomext got ill=%0h mdu=%h opc=%h exp 1/0/0", b_ill, b_mdu, b_opc); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0h exp 0", a_valid); end
    endtask

    task automatic test_stall();
        ready = 1'b0; valid = 1'b1;
        inst = 32'h00100093; pc = 32'h300;
        tick();
        checks++; if (a_valid !== 1'b1 || a_imm !== 32'd1 || a_alu !== E_ADD)
            begin errors++; $display("FAIL stall_first got v=%0h imm=%h alu=%h exp 1/1/%h", a_valid, a_imm, a_alu, E_ADD); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL stall_ready1 got %0h exp 1", a_ready); end
        inst = 32'h00200113; pc = 32'h304;
        tick();
        checks++; if (a_imm !== 32'd1 || a_rd !== 5'd1 || a_pc !== 32'h300)
            begin errors++; $display("FAIL stall_hold1 got imm=%h rd=%0d pc=%h exp 1/1/300", a_imm, a_rd, a_pc); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL stall_skid_full got %0h exp 0", a_ready); end
        inst = 32'h00300193; pc = 32'h308;
        tick();
        checks++; if (a_imm !== 32'd1 || a_valid !== 1'b1 || a_ready !== 1'b0)
            begin errors++; $display("FAIL stall_hold2 got imm=%h v=%0h rdy=%0h exp 1/1/0", a_imm, a_valid, a_ready); end
        ready = 1'b1;
        tick();
        checks++; if (a_imm !== 32'd2 || a_rd !== 5'd2 || a_valid !== 1'b1)
            begin errors++; $display("FAIL stall_second got imm=%h rd=%0d v=%0h exp 2/2/1", a_imm, a_rd, a_valid); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_back got %0h exp 1", a_ready); end
        tick();
        valid = 1'b0;
        checks++; if (a_imm !== 32'd3 || a_pc !== 32'h308 || a_valid !== 1'b1)
            begin errors++; $display("FAIL stall_third got imm=%h pc=%h v=%0h exp 3/308/1", a_imm, a_pc, a_valid); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup got %0h exp 0", a_valid); end
    endtask

    task automatic test_flush();
        ready = 1'b0; valid = 1'b1;
        inst = 32'h00100093; pc = 32'h400;
        tick();
        inst = 32'h00200113; pc = 32'h404;
        tick();
        checks++; if (a_ready !== 1'b0 || a_valid !== 1'b1)
            begin errors++; $display("FAIL flush_setup got rdy=%0h v=%0h exp 0/1", a_ready, a_valid); end
        inst = 32'h00300193; pc = 32'h408; flush = 1'b1;
        tick();
        flush = 1'b0; valid = 1'b0; ready = 1'b1;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h exp 0", a_valid); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0h exp 1", a_ready); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL flush_skid_dropped got %0h exp 0", a_valid); end
        // Flush overriding an accepted input
        inst = 32'h00400213; pc = 32'h40C; valid = 1'b1; flush = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1)
            begin errors++; $display("FAIL flush_ready_normal got a=%0h b=%0h exp 1/1", a_ready, b_ready); end
        tick();
        flush = 1'b0; valid = 1'b0;
        checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0)
            begin errors++; $display("FAIL flush_drop_input got a=%0h b=%0h exp 0/0", a_valid, b_valid); end
        tick();
        checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0)
            begin errors++; $display("FAIL flush_never_appears got a=%0h b=%0h exp 0/0", a_valid, b_valid); end
    endtask

    typedef struct packed {
        logic [31:0] inst;
        logic        a_ill;
        logic [10:0] opc;
        logic [13:0] alu;
        logic [2:0]  sys;
        logic [31:0] imm;
        logic        b_ill;
    } vec_t;

    task automatic test_illegal();
        vec_t vecs [14];
        vecs = '{
            '{32'h00000000, 1'b1, 11'h0,    14'h0,  3'b000, 32'h00000000, 1'b1},
            '{32'h011081B3, 1'b0, E_RTYPE,  E_ADD,  3'b000, 32'h00000000, 1'b1},
            '{32'h00000073, 1'b0, E_SYSTEM, E_ADD,  3'b001, 32'h00000000, 1'b0},
            '{32'h00100073, 1'b0, E_SYSTEM, E_ADD,  3'b010, 32'h00000001, 1'b0},
            '{32'h30200073, 1'b0, E_SYSTEM, E_ADD,  3'b100, 32'h00000302, 1'b0},
            '{32'h00002063, 1'b1, 11'h0,    14'h0,  3'b000, 32'h00000000, 1'b1},
            '{32'hFE209EE3, 1'b0, E_BRANCH, E_NEQ,  3'b000, 32'hFFFFFFFC, 1'b0},
            '{32'h00001067, 1'b1, 11'h0,    14'h0,  3'b000, 32'h00000000, 1'b1},
            '{32'h4010D093, 1'b0, E_ITYPE,  E_SRA,  3'b000, 32'h00000401, 1'b0},
            '{32'h2010D093, 1'b1, 11'h0,    14'h0,  3'b000, 32'h00000201, 1'b1},
            '{32'hFFF0A103, 1'b0, E_LOAD,   E_ADD,  3'b000, 32'hFFFFFFFF, 1'b0},
            '{32'h4000F0B3, 1'b1, 11'h0,    14'h0,  3'b000, 32'h00000000, 1'b1},
            '{32'h008000EF, 1'b0, E_JAL,    E_ADD,  3'b000, 32'h00000008, 1'b0},
            '{32'hFE20AC23, 1'b0, E_STORE,  E_ADD,  3'b000, 32'hFFFFFFF8, 1'b0}
        };
        ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            inst = vecs[i].inst; pc = 32'h500 + 32'(i * 4); valid = 1'b1;
            tick();
            checks++; if (a_valid !== 1'b1 || a_ill !== vecs[i].a_ill)
                begin errors++; $display("FAIL dec%0d_ill inst=%h got v=%0h ill=%0h exp 1/%0h", i, vecs[i].inst, a_valid, a_ill, vecs[i].a_ill); end
            checks++; if (a_opc !== vecs[i].opc || a_alu !== vecs[i].alu)
                begin errors++; $display("FAIL dec%0d_op inst=%h got opc=%h alu=%h exp %h/%h", i, vecs[i].inst, a_opc, a_alu, vecs[i].opc, vecs[i].alu); end
            checks++; if (a_sys !== vecs[i].sys || a_imm !== vecs[i].imm)
                begin errors++; $display("FAIL dec%0d_sysimm inst=%h got sys=%b imm=%h exp %b/%h", i, vecs[i].inst, a_sys, a_imm, vecs[i].sys, vecs[i].imm); end
            checks++; if (b_valid !== 1'b1 || b_ill !== vecs[i].b_ill)
                begin errors++; $display("FAIL dec%0d_rv32e inst=%h got v=%0h ill=%0h exp 1/%0h", i, vecs[i].inst, b_valid, b_ill, vecs[i].b_ill); end
        end
        valid = 1'b0;
        tick();
        checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0)
            begin errors++; $display("FAIL dec_drain got a=%0h b=%0h exp 0/0", a_valid, b_valid); end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_back_to_back();
        test_stall();
        test_flush();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
